// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between the interconnect and a memory slave.
// Slave modport is the memory side; Master modport is the interconnect side.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    // Every channel transfers on a rising edge where valid && ready; a source never
    // withdraws or alters its payload while valid is high and ready is low.
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: byte-strobed word array, independent read and write FSMs, one burst each.
// Define AXI_MEM_ERR_RESP_EN to answer out-of-range requests with SLVERR instead of aliasing.
module axi_mem_slave #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned MEM_BYTES      = 16384,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input logic   clk,
    input logic   rst_n,
    AXI_BUS.Slave slave
);
    localparam int unsigned AW    = AXI_ADDR_WIDTH;
    localparam int unsigned DW    = AXI_DATA_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned WORDS = MEM_BYTES / 8;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef AXI_MEM_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Upper offset bits fall away here, which is what makes the region alias.
    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE_ADDR;
        return (WORDS == 1) ? '0 : IW'(off >> 3);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] burst,
                                                input logic [2:0] size);
        logic [2:0] sz;
        sz = (size > 3'd3) ? 3'd3 : size;
        return (burst == 2'b00) ? a : a + (AW'(1) << sz);
    endfunction

    function automatic logic range_err(input logic [AW-1:0] a);
        return ERR_EN && ((a - BASE_ADDR) >= AW'(MEM_BYTES));
    endfunction

    logic [DW-1:0] mem_q [WORDS];

    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [AW-1:0]             w_addr_q, w_addr_d;
    logic [7:0]                w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]                w_burst_q, w_burst_d;
    logic [2:0]                w_size_q, w_size_d;
    logic [AXI_USER_WIDTH-1:0] w_user_q, w_user_d;
    logic                      w_err_q, w_err_d;
    logic                      aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic                      mem_we;

    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [AW-1:0]             r_addr_q, r_addr_d, r_next_addr;
    logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]                r_burst_q, r_burst_d;
    logic [2:0]                r_size_q, r_size_d;
    logic [AXI_USER_WIDTH-1:0] r_user_q, r_user_d;
    logic                      r_err_q, r_err_d;
    logic                      ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [DW-1:0]             r_data_q, r_data_d;

    logic unused_w;
    assign unused_w = ^{slave.w_last, slave.w_user};

    // Write channel
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_size_d  = w_size_q;
        w_user_d  = w_user_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (slave.aw_valid && aw_ready_q) begin
                w_id_d    = slave.aw_id;
                w_addr_d  = slave.aw_addr;
                w_len_d   = slave.aw_len;
                w_burst_d = slave.aw_burst;
                w_size_d  = slave.aw_size;
                w_user_d  = slave.aw_user;
                w_err_d   = range_err(slave.aw_addr);
                w_cnt_d   = '0;
                w_state_d = W_DATA;
            end
            // Beat count, not w_last, closes the burst.
            W_DATA: if (slave.w_valid && w_ready_q) begin
                mem_we   = !w_err_q;
                w_addr_d = next_addr(w_addr_q, w_burst_q, w_size_q);
                w_cnt_d  = w_cnt_q + 8'd1;
                if (w_cnt_q == w_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (slave.b_ready && b_valid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        b_valid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_burst_q  <= '0;
            w_size_q   <= '0;
            w_user_q   <= '0;
            w_err_q    <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_burst_q  <= w_burst_d;
            w_size_q   <= w_size_d;
            w_user_q   <= w_user_d;
            w_err_q    <= w_err_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
                if (slave.w_strb[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= slave.w_data[8*b +: 8];
            end
        end
    end

    // Read channel; array reads see pre-edge contents, so a same-cycle write is not forwarded.
    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_burst_d   = r_burst_q;
        r_size_d    = r_size_q;
        r_user_d    = r_user_q;
        r_err_d     = r_err_q;
        r_last_d    = r_last_q;
        r_data_d    = r_data_q;
        r_next_addr = next_addr(r_addr_q, r_burst_q, r_size_q);
        case (r_state_q)
            R_IDLE: if (slave.ar_valid && ar_ready_q) begin
                r_id_d    = slave.ar_id;
                r_addr_d  = slave.ar_addr;
                r_len_d   = slave.ar_len;
                r_burst_d = slave.ar_burst;
                r_size_d  = slave.ar_size;
                r_user_d  = slave.ar_user;
                r_err_d   = range_err(slave.ar_addr);
                r_cnt_d   = '0;
                r_data_d  = r_err_d ? '0 : mem_q[word_idx(slave.ar_addr)];
                r_last_d  = (slave.ar_len == 8'd0);
                r_state_d = R_DATA;
            end
            R_DATA: if (slave.r_ready && r_valid_q) begin
                if (r_last_q) begin
                    r_last_d  = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = r_next_addr;
                    r_cnt_d  = r_cnt_q + 8'd1;
                    r_data_d = r_err_q ? '0 : mem_q[word_idx(r_next_addr)];
                    r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_burst_q  <= '0;
            r_size_q   <= '0;
            r_user_q   <= '0;
            r_err_q    <= 1'b0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
        end else begin
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            r_burst_q  <= r_burst_d;
            r_size_q   <= r_size_d;
            r_user_q   <= r_user_d;
            r_err_q    <= r_err_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
        end
    end

    assign slave.aw_ready = aw_ready_q;
    assign slave.w_ready  = w_ready_q;
    assign slave.b_valid  = b_valid_q;
    assign slave.b_id     = w_id_q;
    assign slave.b_user   = w_user_q;
    assign slave.b_resp   = {w_err_q, 1'b0};
    assign slave.ar_ready = ar_ready_q;
    assign slave.r_valid  = r_valid_q;
    assign slave.r_last   = r_last_q;
    assign slave.r_data   = r_data_q;
    assign slave.r_id     = r_id_q;
    assign slave.r_user   = r_user_q;
    assign slave.r_resp   = {r_err_q, 1'b0};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: directed cases plus random bursts against a byte-address memory model.
module tb_axi_mem_slave;
    localparam int unsigned MEMB  = 1024;
    localparam int unsigned WORDS = MEMB / 8;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          BUDGET = 200;

    logic clk;
    logic rst_n;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) bus ();

    axi_mem_slave #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1),
        .MEM_BYTES(MEMB), .BASE_ADDR(BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .slave (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int r_mode = 0;
    int r_beats = 0;
    int burst_beats = 0;
    int first_cyc = 0;
    int last_span = 0;
    int last_beats = 0;

    logic [63:0] ref_mem [WORDS];
    logic [7:0]  exp_b_q [$];
    logic [72:0] exp_r_q [$];
    logic [63:0] wd_buf [256];
    logic [7:0]  ws_buf [256];

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model
    function automatic int beat_word(input logic [63:0] start, input int k, input logic [2:0] size,
                                     input logic [1:0] burst);
        logic [63:0] a;
        logic [63:0] off;
        int sz;
        sz  = (size > 3'd3) ? 3 : int'(size);
        a   = (burst == 2'b00) ? start : start + 64'(k) * (64'd1 << sz);
        off = a - BASE;
        return int'((off % 64'(MEMB)) / 64'd8);
    endfunction

    function automatic bit is_err(input logic [63:0] start);
`ifdef AXI_MEM_ERR_RESP_EN
        return (start - BASE) >= 64'(MEMB);
`else
        return (start - BASE) != (start - BASE);
`endif
    endfunction

    // Driver tasks
    task automatic wait_ready(input string name, input int which);
        int t;
        logic r;
        t = 0;
        forever begin
            @(negedge clk);
            r = (which == 0) ? bus.aw_ready : (which == 1) ? bus.w_ready : bus.ar_ready;
            if (r) break;
            t++;
            if (t > BUDGET) begin
                errors++;
                checks++;
                $display("FAIL %s_timeout: ready=0 for %0d cycles, expected 1", name, t);
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int which);
        int t;
        t = 0;
        while (((which == 0) ? exp_b_q.size() : exp_r_q.size()) != 0) begin
            @(negedge clk);
            t++;
            if (t > 3000) begin
                errors++;
                checks++;
                $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name,
                         (which == 0) ? exp_b_q.size() : exp_r_q.size());
                if (which == 0) exp_b_q.delete(); else exp_r_q.delete();
                break;
            end
        end
    endtask

    task automatic do_write(input logic [4:0] id, input logic [63:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic user);
        bit err;
        int w;
        err = is_err(addr);
        exp_b_q.push_back({id, (err ? 2'b10 : 2'b00), user});
        if (!err) begin
            for (int k = 0; k <= len; k++) begin
                w = beat_word(addr, k, size, burst);
                for (int b = 0; b < 8; b++)
                    if (ws_buf[k][b]) ref_mem[w][8*b +: 8] = wd_buf[k][8*b +: 8];
            end
        end
        @(posedge clk); #1;
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = 8'(len);
        bus.aw_size = size; bus.aw_burst = burst; bus.aw_user = user; bus.aw_valid = 1'b1;
        wait_ready("aw", 0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.w_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.w_data = wd_buf[k]; bus.w_strb = ws_buf[k];
            bus.w_last = (k == len); bus.w_user = user; bus.w_valid = 1'b1;
            wait_ready("w", 1);
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        wait_drain("b", 0);
    endtask

    task automatic push_read(input logic [4:0] id, input logic [63:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input logic user);
        bit err;
        logic [63:0] d;
        err = is_err(addr);
        for (int k = 0; k <= len; k++) begin
            d = err ? 64'd0 : ref_mem[beat_word(addr, k, size, burst)];
            exp_r_q.push_back({id, user, (err ? 2'b10 : 2'b00), (k == len), d});
        end
    endtask

    task automatic issue_ar(input logic [4:0] id, input logic [63:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic user);
        @(posedge clk); #1;
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = 8'(len);
        bus.ar_size = size; bus.ar_burst = burst; bus.ar_user = user; bus.ar_valid = 1'b1;
        wait_ready("ar", 2);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] id, input logic [63:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user);
        push_read(id, addr, len, size, burst, user);
        issue_ar(id, addr, len, size, burst, user);
        @(negedge clk);
        chk("r_first_beat_latency", bus.r_valid, 1'b1);
        wait_drain("r", 1);
    endtask

    // Response-ready drivers
    initial begin
        bus.b_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.b_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        int p;
        p = 0;
        bus.r_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (r_mode == 0) bus.r_ready = 1'b1;
            else if (r_mode == 1) bus.r_ready = ($urandom_range(0, 1) == 1);
            else bus.r_ready = ((p % 3) == 0);
            p++;
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        logic [72:0] held;
        logic [72:0] act;
        logic [72:0] e;
        logic [7:0]  eb;
        bit stall_prev;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (bus.b_valid && bus.b_ready) begin
                    if (exp_b_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got id=%0h resp=%0h, expected no response", bus.b_id, bus.b_resp);
                    end else begin
                        eb = exp_b_q.pop_front();
                        chk("b_channel_id_resp_user", {bus.b_id, bus.b_resp, bus.b_user}, eb);
                    end
                end
                act = {bus.r_id, bus.r_user, bus.r_resp, bus.r_last, bus.r_data};
                if (stall_prev) begin
                    chk("r_valid_hold", bus.r_valid, 1'b1);
                    chk("r_fields_hold", act, held);
                end
                stall_prev = bus.r_valid && !bus.r_ready;
                held = act;
                if (bus.r_valid && bus.r_ready) begin
                    r_beats++;
                    if (exp_r_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected: got data=%0h, expected no beat", bus.r_data);
                    end else begin
                        e = exp_r_q.pop_front();
                        chk("r_beat_id_user_resp_last_data", act, e);
                        if (burst_beats == 0) first_cyc = cyc;
                        burst_beats++;
                        if (e[64]) begin
                            last_span   = cyc - first_cyc;
                            last_beats  = burst_beats;
                            burst_beats = 0;
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int base_beats;
        logic [63:0] old;
        bit is_wr;
        int len;
        logic [2:0] size;
        logic [1:0] burst;
        logic [63:0] addr;

        rst_n = 1'b0;
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0;
        bus.aw_size = 0; bus.aw_burst = 0; bus.aw_user = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0; bus.w_user = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0;
        bus.ar_size = 0; bus.ar_burst = 0; bus.ar_user = 0;

        @(negedge clk);
        chk("reset_outputs", {bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid, bus.r_valid,
                              bus.r_last, bus.b_resp, bus.r_resp, bus.b_id, bus.r_id, bus.r_data,
                              bus.b_user, bus.r_user}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill the whole array so every later read has a known value.
        r_mode = 0;
        for (int k = 0; k < WORDS; k++) begin
            wd_buf[k] = {$urandom, $urandom};
            ws_buf[k] = 8'hFF;
        end
        do_write(5'd1, BASE, WORDS - 1, 3'd3, 2'b01, 1'b0);

        // Single write then read
        wd_buf[0] = 64'hDEADBEEF_F457F00D; ws_buf[0] = 8'hFF;
        do_write(5'h13, BASE + 64'h40, 0, 3'd3, 2'b01, 1'b1);
        do_read(5'h0A, BASE + 64'h40, 0, 3'd3, 2'b01, 1'b1);

        // INCR burst, full throughput
        for (int k = 0; k < 4; k++) begin
            wd_buf[k] = 64'(k);
            ws_buf[k] = 8'hFF;
        end
        do_write(5'd2, BASE, 3, 3'd3, 2'b01, 1'b0);
        do_read(5'd3, BASE, 3, 3'd3, 2'b01, 1'b0);
        chk("incr_beats", 32'(last_beats), 32'd4);
        chk("incr_consecutive_span", 32'(last_span), 32'd3);

        // Same burst under 1,0,0 backpressure
        r_mode = 2;
        do_read(5'd4, BASE, 3, 3'd3, 2'b01, 1'b0);
        chk("backpressure_beats", 32'(last_beats), 32'd4);
        r_mode = 0;

        // Strobe merge
        wd_buf[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws_buf[0] = 8'hFF;
        do_write(5'd5, BASE + 64'h8, 0, 3'd3, 2'b01, 1'b0);
        wd_buf[0] = 64'd0; ws_buf[0] = 8'h0F;
        do_write(5'd5, BASE + 64'h8, 0, 3'd3, 2'b01, 1'b0);
        do_read(5'd6, BASE + 64'h8, 0, 3'd3, 2'b01, 1'b0);

        // FIXED and narrow INCR
        do_read(5'd7, BASE + 64'h18, 3, 3'd3, 2'b00, 1'b0);
        do_read(5'd8, BASE + 64'h20, 9, 3'd1, 2'b01, 1'b1);

        // Same-word read and write on one edge: read returns old data
        addr = BASE + 64'h60;
        old = ref_mem[12];
        exp_r_q.push_back({5'd9, 1'b0, 2'b00, 1'b1, old});
        exp_b_q.push_back({5'd10, 2'b00, 1'b0});
        ref_mem[12] = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        bus.aw_id = 5'd10; bus.aw_addr = addr; bus.aw_len = 0; bus.aw_size = 3; bus.aw_burst = 1;
        bus.aw_user = 0; bus.aw_valid = 1'b1;
        wait_ready("aw_coincident", 0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        bus.w_data = 64'h0123_4567_89AB_CDEF; bus.w_strb = 8'hFF; bus.w_last = 1; bus.w_valid = 1;
        bus.ar_id = 5'd9; bus.ar_addr = addr; bus.ar_len = 0; bus.ar_size = 3; bus.ar_burst = 1;
        bus.ar_user = 0; bus.ar_valid = 1'b1;
        @(negedge clk);
        chk("coincident_w_ar_ready", {bus.w_ready, bus.ar_ready}, 2'b11);
        @(posedge clk); #1;
        bus.w_valid = 0; bus.w_last = 0; bus.ar_valid = 0;
        wait_drain("r_coincident", 1);
        wait_drain("b_coincident", 0);
        do_read(5'd11, addr, 0, 3'd3, 2'b01, 1'b0);

        // Out-of-range: SLVERR with the feature, alias to word 0 without it
        wd_buf[0] = 64'hA5A5_5A5A_0F0F_F0F0; ws_buf[0] = 8'hFF;
        do_write(5'd12, BASE + 64'(MEMB), 0, 3'd3, 2'b01, 1'b0);
        do_read(5'd13, BASE, 0, 3'd3, 2'b01, 1'b0);
        do_read(5'd14, BASE + 64'(MEMB), 1, 3'd3, 2'b01, 1'b1);

        // Reset in the middle of a read burst
        push_read(5'd15, BASE, 7, 3'd3, 2'b01, 1'b0);
        base_beats = r_beats;
        issue_ar(5'd15, BASE, 7, 3'd3, 2'b01, 1'b0);
        for (int t = 0; t < BUDGET && r_beats < base_beats + 2; t++) @(negedge clk);
        chk("reset_burst_progress", 32'(r_beats - base_beats), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_r_q.delete();
        burst_beats = 0;
        @(negedge clk);
        chk("midreset_r_valid", bus.r_valid, 1'b0);
        chk("midreset_ar_ready", bus.ar_ready, 1'b0);
        chk("midreset_aw_ready_b_valid_r_last", {bus.aw_ready, bus.b_valid, bus.r_last}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ar_ready_after_release", bus.ar_ready, 1'b1);
        chk("aw_ready_after_release", bus.aw_ready, 1'b1);
        do_read(5'd16, BASE, 7, 3'd3, 2'b01, 1'b0);

        // Random bursts with random backpressure
        r_mode = 1;
        for (int n = 0; n < 40; n++) begin
            is_wr = ($urandom_range(0, 1) == 1);
            len   = $urandom_range(0, 15);
            size  = 3'($urandom_range(0, 4));
            burst = 2'($urandom_range(0, 2));
            addr  = BASE + 64'($urandom_range(0, 2 * MEMB - 1));
            if (is_wr) begin
                for (int k = 0; k <= len; k++) begin
                    wd_buf[k] = {$urandom, $urandom};
                    ws_buf[k] = 8'($urandom_range(0, 255));
                end
                do_write(5'($urandom_range(0, 31)), addr, len, size, burst, 1'($urandom_range(0, 1)));
            end else begin
                do_read(5'($urandom_range(0, 31)), addr, len, size, burst, 1'($urandom_range(0, 1)));
            end
        end
        r_mode = 0;
        do_read(5'd17, BASE, WORDS - 1, 3'd3, 2'b01, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'({exp_b_q.size(), exp_r_q.size()}), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
